rp_scope_calib_mc: RTL and testbench



---
 rtl/rp_scope_calib_mc.sv | 170 +++++++++++++++++
 tb/tb_rp_scope_calib_mc.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rp_scope_calib_mc.sv
// rp_scope_calib_mc: multi-channel scope calibration stage.
// Per-channel signed offset, then unsigned fixed-point gain with round-half-up
// and saturation, in a 5-stage AXI-Stream pipeline that shares one handshake.
// Optional build macro RP_CALIB_SAT_CNT_EN adds per-channel 16-bit saturation
// counters; without it calib_sat_cnt_o is tied to zero.
module rp_scope_calib_mc #(
   parameter int unsigned CH    = 2,
   parameter int unsigned DBITS = 16,
   parameter int unsigned GBITS = 16,
   parameter int unsigned GFRAC = 15
) (
   input  logic                  adc_clk_i,
   input  logic                  adc_rstn_i,
   input  logic [CH*DBITS-1:0]   calib_dat_i,
   input  logic                  calib_din_tvalid_i,
   output logic                  calib_din_tready_o,
   output logic [CH*DBITS-1:0]   calib_dat_o,
   output logic                  calib_dout_tvalid_o,
   input  logic                  calib_dout_tready_i,
   input  logic [CH*DBITS-1:0]   cfg_calib_offset_i,
   input  logic [CH*GBITS-1:0]   cfg_calib_gain_i,
   input  logic                  cfg_update_i,
   output logic [CH-1:0]         calib_sat_o,
   input  logic                  calib_sat_clr_i,
   output logic [CH*16-1:0]      calib_sat_cnt_o
);

   localparam int unsigned SW = DBITS + 1;
   localparam int unsigned PW = DBITS + GBITS + 1;
   localparam int unsigned CW = 16;
   localparam logic signed [DBITS-1:0] DMAX   = {1'b0, {(DBITS-1){1'b1}}};
   localparam logic signed [DBITS-1:0] DMIN   = {1'b1, {(DBITS-1){1'b0}}};
   localparam logic        [GBITS-1:0] GUNITY = GBITS'(1) << GFRAC;
   localparam logic signed [PW-1:0]    RND    = PW'(1) << (GFRAC - 1);

   logic en;
   logic v1, v2, v3, v4, v5;

   // Whole pipeline advances only when the output register can move.
   assign en                  = !v5 || calib_dout_tready_i;
   assign calib_din_tready_o  = en;
   assign calib_dout_tvalid_o = v5;

   // Valid bit travelling alongside the data through the five stages.
   always_ff @(posedge adc_clk_i) begin
      if (!adc_rstn_i) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         v4 <= 1'b0;
         v5 <= 1'b0;
      end else if (en) begin
         v1 <= calib_din_tvalid_i;
         v2 <= v1;
         v3 <= v2;
         v4 <= v3;
         v5 <= v4;
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic signed [DBITS-1:0] off_act, d1, o2, y5;
      logic        [GBITS-1:0] gain_act, g2;
      logic signed [PW-1:0]    p3, r4;
      logic                    os2, os3, os4, sat_q;
      logic signed [SW-1:0]    sum_c;
      logic signed [DBITS-1:0] o_c, y_c;
      logic                    os_c, gs_c, ev_c;
      logic signed [PW-1:0]    a_c, b_c, pr_c, rnd_c, r_c;

      // Active config: all channels load from the shadow in the same cycle.
      always_ff @(posedge adc_clk_i) begin
         if (!adc_rstn_i) begin
            off_act  <= '0;
            gain_act <= GUNITY;
         end else if (cfg_update_i) begin
            off_act  <= cfg_calib_offset_i[c*DBITS +: DBITS];
            gain_act <= cfg_calib_gain_i[c*GBITS +: GBITS];
         end
      end

      // Offset add at DBITS+1 bits with saturation back to DBITS.
      always_comb begin
         sum_c = SW'(d1) + SW'(off_act);
         os_c  = sum_c[SW-1] ^ sum_c[SW-2];
         o_c   = sum_c[DBITS-1:0];
         if (os_c) begin
            o_c = sum_c[SW-1] ? DMIN : DMAX;
         end
      end

      // Signed product with zero-extended gain, then round-half-up and shift.
      always_comb begin
         a_c   = PW'(o2);
         b_c   = PW'(g2);
         pr_c  = a_c * b_c;
         rnd_c = p3 + RND;
         r_c   = rnd_c >>> GFRAC;
      end

      // Final saturation; event only for a valid sample entering the output reg.
      always_comb begin
         gs_c = !((&r4[PW-1:DBITS-1]) || !(|r4[PW-1:DBITS-1]));
         y_c  = r4[DBITS-1:0];
         if (gs_c) begin
            y_c = r4[PW-1] ? DMIN : DMAX;
         end
         ev_c = en && v4 && (os4 || gs_c);
      end

      // Data path registers; gain is carried from S2 so it pairs with the offset.
      always_ff @(posedge adc_clk_i) begin
         if (!adc_rstn_i) begin
            d1  <= '0;
            o2  <= '0;
            g2  <= '0;
            os2 <= 1'b0;
            p3  <= '0;
            os3 <= 1'b0;
            r4  <= '0;
            os4 <= 1'b0;
            y5  <= '0;
         end else if (en) begin
            d1  <= calib_dat_i[c*DBITS +: DBITS];
            o2  <= o_c;
            g2  <= gain_act;
            os2 <= os_c;
            p3  <= pr_c;
            os3 <= os2;
            r4  <= r_c;
            os4 <= os3;
            y5  <= y_c;
         end
      end

      // Sticky flag: a coincident event wins over clear.
      always_ff @(posedge adc_clk_i) begin
         if (!adc_rstn_i) begin
            sat_q <= 1'b0;
         end else begin
            sat_q <= ev_c | (sat_q & !calib_sat_clr_i);
         end
      end

      assign calib_dat_o[c*DBITS +: DBITS] = y5;
      assign calib_sat_o[c]                = sat_q;

`ifdef RP_CALIB_SAT_CNT_EN
      logic [CW-1:0] cnt;

      // Saturating event counter; clear with a coincident event restarts at 1.
      always_ff @(posedge adc_clk_i) begin
         if (!adc_rstn_i) begin
            cnt <= '0;
         end else if (calib_sat_clr_i) begin
            cnt <= CW'(ev_c);
         end else if (ev_c && (cnt != {CW{1'b1}})) begin
            cnt <= cnt + CW'(1);
         end
      end

      assign calib_sat_cnt_o[c*CW +: CW] = cnt;
`endif
   end

`ifndef RP_CALIB_SAT_CNT_EN
   assign calib_sat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rp_scope_calib_mc.sv
// Self-checking bench for rp_scope_calib_mc: directed cases plus randomized
// streams with backpressure, checked against a transaction-level model.
module tb_rp_scope_calib_mc;

   localparam int unsigned CH    = 2;
   localparam int unsigned DBITS = 16;
   localparam int unsigned GBITS = 16;
   localparam int unsigned GFRAC = 15;
   localparam int DMAX  = 32767;
   localparam int DMIN  = -32768;
   localparam int UNITY = 1 << GFRAC;

   logic                clk = 1'b0;
   logic                rstn = 1'b0;
   logic [CH*DBITS-1:0] din = '0;
   logic                din_tvalid = 1'b0;
   logic                din_tready;
   logic [CH*DBITS-1:0] dout;
   logic                dout_tvalid;
   logic                dout_tready = 1'b1;
   logic [CH*DBITS-1:0] cfg_off = '0;
   logic [CH*GBITS-1:0] cfg_gain = '0;
   logic                cfg_update = 1'b0;
   logic [CH-1:0]       sat;
   logic                sat_clr = 1'b0;
   logic [CH*16-1:0]    sat_cnt;

   always #5 clk = ~clk;

   rp_scope_calib_mc #(.CH(CH), .DBITS(DBITS), .GBITS(GBITS), .GFRAC(GFRAC)) dut (
      .adc_clk_i           (clk),
      .adc_rstn_i          (rstn),
      .calib_dat_i         (din),
      .calib_din_tvalid_i  (din_tvalid),
      .calib_din_tready_o  (din_tready),
      .calib_dat_o         (dout),
      .calib_dout_tvalid_o (dout_tvalid),
      .calib_dout_tready_i (dout_tready),
      .cfg_calib_offset_i  (cfg_off),
      .cfg_calib_gain_i    (cfg_gain),
      .cfg_update_i        (cfg_update),
      .calib_sat_o         (sat),
      .calib_sat_clr_i     (sat_clr),
      .calib_sat_cnt_o     (sat_cnt)
   );

   typedef struct {
      int y0;
      int y1;
      bit s0;
      bit s1;
   } exp_t;

   int   errors = 0;
   int   checks = 0;
   exp_t q[$];
   int   m_off[CH];
   int   m_gain[CH];
   bit   m_flag[CH];
   int   m_cnt[CH];
   int   last_out[CH];
   int   n_out = 0;
   bit   stream_done;

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int sl(input logic [CH*DBITS-1:0] v, input int c);
      return int'($signed(v[c*DBITS +: DBITS]));
   endfunction

   function automatic int exp_cnt(input int v);
`ifdef RP_CALIB_SAT_CNT_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   // Reference: clamp(x+off), then clamp(round_half_up(o*g / 2^GFRAC)).
   function automatic void ref_calc(input int x, input int off, input int g,
                                    output int y, output bit s);
      int     o;
      longint r;
      s = 1'b0;
      o = x + off;
      if (o > DMAX) begin o = DMAX; s = 1'b1; end
      else if (o < DMIN) begin o = DMIN; s = 1'b1; end
      r = (longint'(o) * longint'(g) + longint'(UNITY / 2)) >>> GFRAC;
      if (r > DMAX) begin r = DMAX; s = 1'b1; end
      else if (r < DMIN) begin r = DMIN; s = 1'b1; end
      y = int'(r);
   endfunction

   // Model: config/clear take effect in the cycle they are strobed, inputs
   // are scored at transfer, outputs compared in order at transfer.
   always @(negedge clk) begin
      exp_t e;
      if (!rstn) begin
         q.delete();
         for (int c = 0; c < CH; c++) begin
            m_off[c] = 0; m_gain[c] = UNITY; m_flag[c] = 1'b0; m_cnt[c] = 0;
         end
      end else begin
         if (cfg_update) begin
            for (int c = 0; c < CH; c++) begin
               m_off[c]  = sl(cfg_off, c);
               m_gain[c] = int'(cfg_gain[c*GBITS +: GBITS]);
            end
         end
         if (sat_clr) begin
            for (int c = 0; c < CH; c++) begin
               m_flag[c] = 1'b0; m_cnt[c] = 0;
            end
         end
         if (din_tvalid && din_tready) begin
            ref_calc(sl(din, 0), m_off[0], m_gain[0], e.y0, e.s0);
            ref_calc(sl(din, 1), m_off[1], m_gain[1], e.y1, e.s1);
            q.push_back(e);
         end
         if (dout_tvalid && dout_tready) begin
            if (q.size() == 0) begin
               check("spurious_out", 1, 0);
            end else begin
               e = q.pop_front();
               check("out_ch0", sl(dout, 0), e.y0);
               check("out_ch1", sl(dout, 1), e.y1);
               last_out[0] = sl(dout, 0);
               last_out[1] = sl(dout, 1);
               n_out++;
               if (e.s0) begin m_flag[0] = 1'b1; if (m_cnt[0] < 65535) m_cnt[0]++; end
               if (e.s1) begin m_flag[1] = 1'b1; if (m_cnt[1] < 65535) m_cnt[1]++; end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until it is accepted.
   task automatic push(input int a, input int b);
      int n = 0;
      din        = {DBITS'(b), DBITS'(a)};
      din_tvalid = 1'b1;
      #1;
      while (!din_tready && n < 100) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (n >= 100) check("push_timeout", n, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      din_tvalid  = 1'b0;
      dout_tready = 1'b1;
      while ((q.size() != 0 || dout_tvalid) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) check("drain_timeout", n, 0);
      tick();
   endtask

   task automatic set_cfg(input int o0, input int o1, input int g0, input int g1);
      cfg_off    = {DBITS'(o1), DBITS'(o0)};
      cfg_gain   = {GBITS'(g1), GBITS'(g0)};
      cfg_update = 1'b1;
      tick();
      cfg_update = 1'b0;
   endtask

   task automatic check_flags(input string tag);
      for (int c = 0; c < CH; c++) begin
         check({tag, "_flag"}, sat[c], m_flag[c]);
         check({tag, "_cnt"}, int'(sat_cnt[c*16 +: 16]), exp_cnt(m_cnt[c]));
      end
   endtask

   task automatic latency_probe(input string tag, input int a, input int b);
      int n = 1;
      push(a, b);
      din_tvalid = 1'b0;
      while (!dout_tvalid && n < 20) begin
         tick();
         n++;
      end
      check(tag, n, 5);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, a, b, o0, o1, g0, g1;

      // Reset defaults.
      repeat (3) tick();
      check("rst_dat", int'(dout), 0);
      check("rst_valid", dout_tvalid, 0);
      check("rst_sat", int'(sat), 0);
      check("rst_cnt", int'(sat_cnt), 0);
      check("rst_ready", din_tready, 1);
      rstn = 1'b1;
      tick();

      // Unity pass-through and 5-clock latency.
      latency_probe("latency", 1000, -1000);
      drain();
      check("unity_ch0", last_out[0], 1000);
      check("unity_ch1", last_out[1], -1000);
      check("unity_sat", int'(sat), 0);

      // Offset 100, gain 0x4000.
      set_cfg(100, 100, 16'h4000, 16'h4000);
      push(301, -301);
      drain();
      check("half_ch0", last_out[0], 201);
      check("half_ch1", last_out[1], -100);

      // Offset saturation at the positive rail.
      set_cfg(10, 10, UNITY, UNITY);
      push(32767, 0);
      drain();
      check("osat_ch0", last_out[0], 32767);
      check("osat_ch1", last_out[1], 10);
      check("osat_flags", int'(sat), 1);
      check("osat_cnt0", int'(sat_cnt[15:0]), exp_cnt(1));
      check_flags("osat");

      // Clear alone, then gain saturation at the negative rail.
      sat_clr = 1'b1; tick(); sat_clr = 1'b0;
      check("clr_flags", int'(sat), 0);
      set_cfg(0, 0, 16'hFFFF, 16'hFFFF);
      push(-20000, 1);
      drain();
      check("gsat_ch0", last_out[0], -32768);
      check("gsat_ch1", last_out[1], 2);
      check("gsat_flags", int'(sat), 1);

      // Clear coinciding with a saturation event: flag stays, count restarts at 1.
      push(-20000, 1);
      din_tvalid = 1'b0;
      repeat (3) tick();
      sat_clr = 1'b1; tick(); sat_clr = 1'b0;
      drain();
      check("coinc_flags", int'(sat), 1);
      check("coinc_cnt0", int'(sat_cnt[15:0]), exp_cnt(1));
      check_flags("coinc");

      // Stream 0..9 with a 3-clock output stall mid-stream.
      set_cfg(0, 0, UNITY, UNITY);
      n0 = n_out;
      fork
         begin
            for (int i = 0; i < 10; i++) push(i, -i);
            din_tvalid = 1'b0;
         end
         begin
            repeat (7) tick();
            dout_tready = 1'b0;
            repeat (3) begin
               #1 check("stall_ready", din_tready, 0);
               tick();
            end
            dout_tready = 1'b1;
         end
      join
      drain();
      check("stall_count", n_out - n0, 10);
      check("stall_last", last_out[0], 9);

      // Config update while the pipeline is full.
      cfg_off  = {DBITS'(-3), DBITS'(7)};
      cfg_gain = {GBITS'(16'h2000), GBITS'(16'h6000)};
      n0 = n_out;
      for (int i = 0; i < 10; i++) begin
         if (i == 5) cfg_update = 1'b1;
         push(i * 100, -i * 100);
         cfg_update = 1'b0;
      end
      drain();
      check("upd_count", n_out - n0, 10);
      check("upd_last_ch0", last_out[0], 680);
      check("upd_last_ch1", last_out[1], -226);

      // Randomized streams with random gaps and backpressure.
      for (int r = 0; r < 6; r++) begin
         o0 = int'($signed(16'($urandom)));
         o1 = int'($signed(16'($urandom_range(0, 511)))) - 256;
         g0 = (r % 3 == 0) ? 0 : int'($urandom_range(0, 65535));
         g1 = (r % 2 == 0) ? 65535 : UNITY;
         set_cfg(o0, o1, g0, g1);
         sat_clr = 1'b1; tick(); sat_clr = 1'b0;
         stream_done = 1'b0;
         fork
            begin
               for (int i = 0; i < 30; i++) begin
                  a = int'($signed(16'($urandom)));
                  b = int'($urandom_range(0, 4000)) - 2000;
                  push(a, b);
                  if ($urandom_range(0, 3) == 0) begin
                     din_tvalid = 1'b0;
                     repeat ($urandom_range(1, 2)) tick();
                  end
               end
               din_tvalid  = 1'b0;
               stream_done = 1'b1;
            end
            begin
               while (!stream_done) begin
                  dout_tready = ($urandom_range(0, 2) != 0);
                  tick();
               end
               dout_tready = 1'b1;
            end
         join
         drain();
         check_flags("rand");
      end

      // Reset with samples in flight: nothing emerges until a fresh input.
      set_cfg(0, 0, UNITY, UNITY);
      for (int i = 0; i < 3; i++) push(50 + i, 60 + i);
      din_tvalid = 1'b0;
      rstn = 1'b0;
      repeat (2) tick();
      rstn = 1'b1;
      repeat (8) begin
         tick();
         check("post_rst_idle", dout_tvalid, 0);
      end
      check("post_rst_sat", int'(sat), 0);
      latency_probe("post_rst_latency", 5, 6);
      drain();
      check("post_rst_ch0", last_out[0], 5);
      check("post_rst_ch1", last_out[1], 6);

      check("queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
